// File: rtl/uart_lcd_fmt_pkg.sv
// Shared constants for uart_rx_lcd_formatter: FSM state codes, HD44780
// command bytes, ASCII control codes and the printable range.
package uart_lcd_fmt_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_CHAR   = 4'd1;
  localparam state_t ST_WRAP   = 4'd2;
  localparam state_t ST_CR     = 4'd3;
  localparam state_t ST_LF     = 4'd4;
  localparam state_t ST_CLR    = 4'd5;
  localparam state_t ST_BS_MV1 = 4'd6;
  localparam state_t ST_BS_SP  = 4'd7;
  localparam state_t ST_BS_MV2 = 4'd8;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

  // LCD word with rs=0 (instruction register)
  function automatic logic [8:0] lcd_cmd(input logic [7:0] d);
    return {1'b0, d};
  endfunction

  // LCD word with rs=1 (data register, character write)
  function automatic logic [8:0] lcd_char(input logic [7:0] d);
    return {1'b1, d};
  endfunction

endpackage

// File: rtl/uart_rx_lcd_formatter.sv
// uart_rx_lcd_formatter: turns received ASCII bytes into {rs,data} words for
// the LCD FIFO while tracking the cursor on a 2-line HD44780 display.
// Optional build macro UART_LCD_DROP_COUNT_EN adds a saturating drop_count
// output counting discarded unsupported bytes.
module uart_rx_lcd_formatter
  import uart_lcd_fmt_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter logic [7:0] LINE1_BASE = 8'h40
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [8:0] fifo_din
`ifdef UART_LCD_DROP_COUNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t          r_state;
  logic [8:0]      r_din;
  logic [CW-1:0]   r_col;
  logic            r_line;

  state_t          w_state_nxt;
  logic [8:0]      w_din_nxt;
  logic [CW-1:0]   w_col_nxt;
  logic            w_line_nxt;

  logic            w_accept;
  logic [7:0]      w_cur_base;
  logic [7:0]      w_oth_base;
  logic [7:0]      w_cur_addr;
  logic [7:0]      w_bs_addr;

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign rx_ready   = !srst && (r_state == ST_IDLE);
  assign fifo_wr_en = !srst && (r_state != ST_IDLE) && !fifo_full;
  assign fifo_din   = srst ? 9'h000 : r_din;

  assign w_accept   = rx_valid && rx_ready;
  assign w_cur_base = r_line ? LINE1_BASE : 8'h00;
  assign w_oth_base = r_line ? 8'h00 : LINE1_BASE;
  assign w_cur_addr = LCD_CMD_DDRAM | (w_cur_base + 8'(r_col));
  // Backspace only starts with col>0, so this never underflows the line.
  assign w_bs_addr  = w_cur_addr - 8'd1;

  // Next-state, next-word and cursor update; each EMIT state advances on a write.
  always_comb begin
    w_state_nxt = r_state;
    w_din_nxt   = r_din;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_printable(rx_data)) begin
            w_state_nxt = ST_CHAR;
            w_din_nxt   = lcd_char(rx_data);
          end else begin
            case (rx_data)
              ASCII_CR: begin
                w_state_nxt = ST_CR;
                w_din_nxt   = lcd_cmd(LCD_CMD_DDRAM | w_cur_base);
              end
              ASCII_LF: begin
                w_state_nxt = ST_LF;
                w_din_nxt   = lcd_cmd(LCD_CMD_DDRAM | w_oth_base);
              end
              ASCII_FF: begin
                w_state_nxt = ST_CLR;
                w_din_nxt   = lcd_cmd(LCD_CMD_CLEAR);
              end
              ASCII_BS: begin
                if (r_col != COL_ZERO) begin
                  w_state_nxt = ST_BS_MV1;
                  w_din_nxt   = lcd_cmd(w_bs_addr);
                end else begin
                  w_state_nxt = ST_IDLE;
                end
              end
              default: begin
                w_state_nxt = ST_IDLE;
              end
            endcase
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHAR: begin
        if (fifo_wr_en) begin
          if (r_col == COL_LAST) begin
            w_state_nxt = ST_WRAP;
            w_din_nxt   = lcd_cmd(LCD_CMD_DDRAM | w_oth_base);
          end else begin
            w_state_nxt = ST_IDLE;
            w_col_nxt   = r_col + COL_ONE;
          end
        end else begin
          w_state_nxt = ST_CHAR;
        end
      end
      ST_WRAP, ST_LF: begin
        if (fifo_wr_en) begin
          w_state_nxt = ST_IDLE;
          w_line_nxt  = !r_line;
          w_col_nxt   = COL_ZERO;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CR: begin
        if (fifo_wr_en) begin
          w_state_nxt = ST_IDLE;
          w_col_nxt   = COL_ZERO;
        end else begin
          w_state_nxt = ST_CR;
        end
      end
      ST_CLR: begin
        if (fifo_wr_en) begin
          w_state_nxt = ST_IDLE;
          w_line_nxt  = 1'b0;
          w_col_nxt   = COL_ZERO;
        end else begin
          w_state_nxt = ST_CLR;
        end
      end
      ST_BS_MV1: begin
        if (fifo_wr_en) begin
          w_state_nxt = ST_BS_SP;
          w_din_nxt   = lcd_char(ASCII_SPACE);
        end else begin
          w_state_nxt = ST_BS_MV1;
        end
      end
      ST_BS_SP: begin
        if (fifo_wr_en) begin
          w_state_nxt = ST_BS_MV2;
          w_din_nxt   = lcd_cmd(w_bs_addr);
        end else begin
          w_state_nxt = ST_BS_SP;
        end
      end
      ST_BS_MV2: begin
        if (fifo_wr_en) begin
          w_state_nxt = ST_IDLE;
          w_col_nxt   = r_col - COL_ONE;
        end else begin
          w_state_nxt = ST_BS_MV2;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM, output word and cursor registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= ST_IDLE;
      r_din   <= 9'h000;
      r_col   <= COL_ZERO;
      r_line  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_din   <= w_din_nxt;
      r_col   <= w_col_nxt;
      r_line  <= w_line_nxt;
    end
  end

`ifdef UART_LCD_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  // A drop is an accepted byte that is neither printable nor a known control
  // code; backspace at column 0 is a known code and is not counted.
  assign w_drop = w_accept && !is_printable(rx_data) &&
                  (rx_data != ASCII_CR) && (rx_data != ASCII_LF) &&
                  (rx_data != ASCII_FF) && (rx_data != ASCII_BS);

  assign drop_count = r_drop_cnt;

  // Saturating count of discarded bytes.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_drop_cnt <= 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_lcd_formatter.sv
// Self-checking bench for uart_rx_lcd_formatter with a cursor-level model.
module tb_uart_rx_lcd_formatter;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready;
  logic       fifo_full = 1'b0;
  logic       fifo_wr_en;
  logic [8:0] fifo_din;
`ifdef UART_LCD_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  logic       force_full = 1'b0;
  logic       rand_full_en = 1'b0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  // reference cursor model
  int m_line = 0;
  int m_col  = 0;
  int m_drops = 0;

  uart_rx_lcd_formatter dut (
    .clk        (clk),
    .srst       (srst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din)
`ifdef UART_LCD_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // fifo_full is driven from one place: random back-pressure or the forced value
  always @(posedge clk) begin
    #2;
    fifo_full = rand_full_en ? ($urandom_range(0, 3) == 0) : force_full;
  end

  // capture every word that will be written at the next rising edge
  always @(negedge clk) begin
    if (fifo_wr_en) obs_q.push_back(fifo_din);
  end

  function automatic logic [8:0] addr_cmd(input int line, input int col);
    logic [7:0] a;
    a = 8'(128 + 64 * line + col);
    return {1'b0, a};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({1'b1, b});
      if (m_col == 15) begin
        m_line = 1 - m_line;
        m_col  = 0;
        exp_q.push_back(addr_cmd(m_line, 0));
      end else begin
        m_col++;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
      exp_q.push_back(addr_cmd(m_line, 0));
    end else if (b == 8'h0A) begin
      m_line = 1 - m_line;
      m_col  = 0;
      exp_q.push_back(addr_cmd(m_line, 0));
    end else if (b == 8'h0C) begin
      m_line = 0;
      m_col  = 0;
      exp_q.push_back(9'h001);
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        exp_q.push_back(addr_cmd(m_line, m_col - 1));
        exp_q.push_back(9'h120);
        exp_q.push_back(addr_cmd(m_line, m_col - 1));
        m_col--;
      end
    end else begin
      if (m_drops < 255) m_drops++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    m_line = 0;
    m_col = 0;
    m_drops = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait_ready: rx_ready=%b required 1 (byte %h)", rx_ready, b);
    end else begin
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      model_byte(b);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready); end
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", fifo_wr_en); end
    checks++;
    if (fifo_din !== 9'h000) begin errors++; $display("FAIL reset_din: got %h required 000", fifo_din); end
    srst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", rx_ready); end
    m_line = 0; m_col = 0; m_drops = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_char_latency();
    do_reset();
    send_byte(8'h41);
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL lat_wr_en: got %b required 1", fifo_wr_en); end
    checks++;
    if (fifo_din !== 9'h141) begin errors++; $display("FAIL lat_din: got %h required 141", fifo_din); end
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_low: got %b required 0", rx_ready); end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_back: got %b required 1", rx_ready); end
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL lat_single_write: got %b required 0", fifo_wr_en); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL lat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lat_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    send_byte(8'h58);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backspace();
    do_reset();
    send_byte(8'h08);
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h08);
    send_byte(8'h08);
    send_byte(8'h08);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bs_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bs_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_controls();
    do_reset();
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    send_byte(8'h0A); send_byte(8'h0D); send_byte(8'h41); send_byte(8'h0D);
    send_byte(8'h0C); send_byte(8'h5A);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ctl_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ctl_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_hold();
    logic [8:0] first;
    do_reset();
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle();
    obs_q.delete(); exp_q.delete();
    force_full = 1'b1;
    @(posedge clk); #3;
    send_byte(8'h08);
    first = exp_q[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL hold_wr_en[%0d]: got %b required 0", k, fifo_wr_en); end
      checks++;
      if (fifo_din !== first) begin errors++; $display("FAIL hold_din[%0d]: got %h required %h", k, fifo_din, first); end
    end
    force_full = 1'b0;
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL hold_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] b;
    do_reset();
    rand_full_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
        5: b = 8'h0D;
        6: b = 8'h0A;
        7: b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h08;
        8: b = 8'h08;
        default: b = 8'($urandom);
      endcase
      send_byte(b);
    end
    rand_full_en = 1'b0;
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle();
    force_full = 1'b1;
    @(posedge clk); #3;
    send_byte(8'h08);
    @(negedge clk);
    srst = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || rx_ready !== 1'b0 || fifo_din !== 9'h000) begin
      errors++;
      $display("FAIL mid_reset_outputs: wr_en=%b ready=%b din=%h required 0 0 000", fifo_wr_en, rx_ready, fifo_din);
    end
    force_full = 1'b0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    obs_q.delete(); exp_q.delete();
    m_line = 0; m_col = 0; m_drops = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL mid_reset_no_writes: got %0d writes required 0", obs_q.size()); end
`ifdef UART_LCD_DROP_COUNT_EN
    checks++;
    if (drop_count !== 8'h00) begin errors++; $display("FAIL mid_reset_drops: got %h required 00", drop_count); end
`endif
    send_byte(8'h5A);
    wait_idle();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL mid_reset_cursor: got %0d words first %h required 1 word %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h000, exp_q[0]);
    end
  endtask

`ifdef UART_LCD_DROP_COUNT_EN
  task automatic test_drop_count();
    do_reset();
    send_byte(8'h00); send_byte(8'h7F); send_byte(8'h1B);
    send_byte(8'h41); send_byte(8'h08); send_byte(8'h08);
    wait_idle();
    checks++;
    if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL drop_small: got %h required %h", drop_count, 8'(m_drops)); end
    for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(128, 255)));
    wait_idle();
    checks++;
    if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL drop_saturate: got %h required %h", drop_count, 8'(m_drops)); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_writes: got %0d required %0d", obs_q.size(), exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_char_latency();
    test_wrap();
    test_backspace();
    test_controls();
    test_full_hold();
    test_back_to_back_random();
    test_reset_mid();
`ifdef UART_LCD_DROP_COUNT_EN
    test_drop_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_lcd_formatter.md
Name: uart_rx_lcd_formatter

Overview:
Sits between the UART receiver output (byte stream from the ESP-01S link) and the 512x9 sync_fifo write port that feeds fifo_to_lcd_adapter. It converts raw ASCII bytes into 9-bit LCD transactions {rs, data}, with rs=1 for a character write and rs=0 for a command. It tracks the cursor position on the 16x2 HD44780 display and handles auto line-wrap, CR, LF, form feed and backspace. Unsupported bytes are dropped.

Parameters:
- COLS, 16, visible characters per line; the wrap point.
- LINE1_BASE, 8'h40, DDRAM address of line 1 (line 0 is 8'h00).

Ports:
- clk  in  1  system clock (MAX10_CLK1_50 domain).
- srst  in  1  synchronous reset, active-high.
- rx_valid  in  1  receiver has a byte.
- rx_data  in  8  received byte.
- rx_ready  out  1  formatter can accept a byte.
- fifo_full  in  1  downstream FIFO full.
- fifo_wr_en  out  1  write strobe to FIFO, one word per cycle.
- fifo_din  out  9  {rs, data} to FIFO.

Behaviour:
- Clocking and reset: one clock, clk. srst is synchronous and active-high.
- Values while srst is high: rx_ready=0, fifo_wr_en=0, fifo_din=9'h000, col=0, line=0, state=IDLE.
- Reset during a sequence: the sequence is abandoned, no further writes occur, and any partially emitted sequence is not completed.
- Accept handshake: rx_ready=1 only in IDLE. A byte is accepted when rx_valid && rx_ready. It is latched and decoded in the same edge.
- Emit handshake: every EMIT state drives fifo_din from registers. fifo_wr_en = (state is EMIT) && !fifo_full, combinationally.
  - The state advances only on a cycle where fifo_wr_en=1.
  - While fifo_full=1 the state holds and fifo_din stays stable.
- Latency: byte accepted at edge N gives the first fifo_wr_en in cycle N+1 (when not full). rx_ready returns high the cycle after the last word of the sequence is written.
- Cursor address: cur_addr = 8'h80 | (line ? LINE1_BASE : 0) + col.
- Decode table (codes are hex):
  - 20..7E printable: emit CHAR {1, byte}. Then col = col+1.
  - Printable, wrap case: if col was COLS-1, emit WRAP {0, 8'h80 | other line base}, toggle line, col=0. Line 1 wraps to line 0; there is no scroll.
  - 0D (CR): emit {0, 8'h80 | current line base}, col=0.
  - 0A (LF): emit {0, 8'h80 | other line base}, toggle line, col=0.
  - 0C (FF): emit {0, 8'h01}, line=0, col=0.
  - 08 (BS), col>0: emit {0, cur_addr-1}, then {1, 8'h20}, then {0, cur_addr-1}. Then col = col-1.
  - 08 (BS), col==0: no emission, returns to IDLE next cycle, not counted as a drop.
  - Any other code: no emission, returns to IDLE next cycle.
- States: IDLE, CHAR, WRAP, CR, LF, CLR, BS_MV1, BS_SP, BS_MV2.
  - Each non-IDLE state except BS_MV1/BS_SP advances to IDLE, except CHAR→WRAP on the wrap condition.
  - BS_MV1→BS_SP→BS_MV2→IDLE.
- Widths: col is $clog2(COLS) bits; line is 1 bit. No arithmetic overflow is possible because wrap occurs at COLS-1.

Optional Feature:
- Macro: UART_LCD_DROP_COUNT_EN.
- Defined: adds output port drop_count [7:0], an 8-bit saturating count (sticks at 8'hFF) of discarded unsupported bytes. It is reset to 0 by srst.
- Not defined: the port and counter are absent, and drop behaviour is otherwise identical.

Decomposition:
- Package uart_lcd_fmt_pkg holds:
  - the state enum;
  - LCD_CMD_CLEAR = 8'h01 and LCD_CMD_DDRAM = 8'h80;
  - ASCII constants CR, LF, FF, BS, SPACE;
  - the PRINT_LO = 8'h20 and PRINT_HI = 8'h7E bounds.
- Single module. No sub-module is warranted because the cursor tracking is a few registers inside the FSM.

Test Plan:
- Reset then send "A" (41), fifo_full=0: exactly one write of 9'h141 in cycle N+1. rx_ready goes low for 1 cycle, then high.
- Send 16 printable bytes 30..3F: 16 writes {1,30..3F}, then one write 9'h0C0. The next byte 'X' is written as 9'h158.
- Send 'A','B',08: writes 141, 142, 081, 120, 081. A second 08 at col 0 of the line gives no write.
- Send 0A, 0D, 0C from line 0 col 3: writes 0C0; then 0C0; then 001 (line=0, col=0). A following 'Z' then writes 15A.
- Hold fifo_full=1 during a backspace sequence for 5 cycles: fifo_wr_en stays 0 and fifo_din is stable. On release the three writes complete in order with none lost or duplicated.
- With UART_LCD_DROP_COUNT_EN: send 00, 7F, 1B: no writes and drop_count=3. Send 300 unsupported bytes: drop_count saturates at FF. Assert srst mid-sequence: no writes after reset and drop_count=0.
